// File: rtl/jtag_arb_pkg.sv
// Shared types and constants for the JTAG/system memory arbiter.
package jtag_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic OWN_JTAG = 1'b0;
  localparam logic OWN_SYS  = 1'b1;

  // Width of the JTAG fairness counter (fair build only).
  localparam int unsigned FAIR_CW = 4;

endpackage

// File: rtl/jtag_arb_ptr.sv
// JTAG auto-increment address pointer: load, increment, wraps modulo 2^AW.
module jtag_arb_ptr #(
  parameter int unsigned AW = 32
) (
  input  logic          clk_p,
  input  logic          rst_top,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top)  ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + AW'(1);
  end

endmodule

// File: rtl/jtag_mem_arbiter.sv
// Two-requester (JTAG / system) arbiter and sequencer for a single-port memory.
// Define JTAG_ARB_FAIR_EN to bound consecutive JTAG grants while the system waits.
module jtag_mem_arbiter
  import jtag_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned FAIR_LIM = 4
) (
  input  logic          clk_p,
  input  logic          rst_top,
  input  logic          jt_req,
  input  logic          jt_we,
  input  logic          jt_inc,
  input  logic [AW-1:0] jt_addr,
  input  logic [DW-1:0] jt_wdata,
  output logic          jt_gnt,
  output logic          jt_rvalid,
  output logic [DW-1:0] jt_rdata,
  input  logic          sys_req,
  input  logic          sys_we,
  input  logic [AW-1:0] sys_addr,
  input  logic [DW-1:0] sys_wdata,
  output logic          sys_gnt,
  output logic          sys_rvalid,
  output logic [DW-1:0] sys_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  if (FAIR_LIM < 1 || FAIR_LIM > 15) begin : g_bad_fair_lim
    $error("jtag_mem_arbiter: FAIR_LIM must be in 1..15");
  end

  state_t        state;
  logic [AW-1:0] ptr;
  logic          sys_win_c;
  logic          jt_win_c;
  logic [AW-1:0] jt_sel_addr_c;

`ifdef JTAG_ARB_FAIR_EN
  localparam logic [FAIR_CW-1:0] FAIR_LIM_C = FAIR_CW'(FAIR_LIM);
  logic [FAIR_CW-1:0] fair_cnt;

  always_comb sys_win_c = sys_req && (!jt_req || (fair_cnt == FAIR_LIM_C));

  // Counts JTAG wins taken over a waiting system request; a system win clears it.
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      fair_cnt <= '0;
    end else if (state == IDLE) begin
      if (sys_win_c)             fair_cnt <= '0;
      else if (jt_req && sys_req) fair_cnt <= fair_cnt + FAIR_CW'(1);
    end
  end
`else
  always_comb sys_win_c = sys_req && !jt_req;
`endif

  always_comb begin
    jt_win_c      = jt_req && !sys_win_c;
    jt_sel_addr_c = jt_inc ? ptr : jt_addr;
  end

  jtag_arb_ptr #(.AW(AW)) u_ptr (
    .clk_p    (clk_p),
    .rst_top  (rst_top),
    .load     ((state == IDLE) && jt_win_c && !jt_inc),
    .inc      ((state == IDLE) && jt_win_c && jt_inc),
    .load_val (jt_addr + AW'(1)),
    .ptr      (ptr)
  );

  // Command is captured straight into the memory-side registers on the IDLE->ISSUE edge.
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      state      <= IDLE;
      jt_gnt     <= 1'b0;
      sys_gnt    <= 1'b0;
      jt_rvalid  <= 1'b0;
      sys_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_JTAG;
    end else begin
      case (state)
        IDLE: begin
          jt_rvalid  <= 1'b0;
          sys_rvalid <= 1'b0;
          if (jt_win_c) begin
            state     <= ISSUE;
            jt_gnt    <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= jt_we;
            mem_addr  <= jt_sel_addr_c;
            mem_wdata <= jt_wdata;
            owner     <= OWN_JTAG;
          end else if (sys_win_c) begin
            state     <= ISSUE;
            sys_gnt   <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= sys_we;
            mem_addr  <= sys_addr;
            mem_wdata <= sys_wdata;
            owner     <= OWN_SYS;
          end
        end
        ISSUE: begin
          state      <= IDLE;
          jt_gnt     <= 1'b0;
          sys_gnt    <= 1'b0;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          jt_rvalid  <= (owner == OWN_JTAG) && !mem_we;
          sys_rvalid <= (owner == OWN_SYS) && !mem_we;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data arrives in the rvalid cycle, so it is gated rather than registered.
  assign jt_rdata  = jt_rvalid  ? mem_rdata : '0;
  assign sys_rdata = sys_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Directed self-checking bench for jtag_mem_arbiter (strict or JTAG_ARB_FAIR_EN build).
module tb_jtag_mem_arbiter;

  logic        clk_p = 1'b0;
  logic        rst_top;
  logic        jt_req, jt_we, jt_inc;
  logic [31:0] jt_addr, jt_wdata;
  logic        jt_gnt, jt_rvalid;
  logic [31:0] jt_rdata;
  logic        sys_req, sys_we;
  logic [31:0] sys_addr, sys_wdata;
  logic        sys_gnt, sys_rvalid;
  logic [31:0] sys_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_p = ~clk_p;

  jtag_mem_arbiter #(.AW(32), .DW(32), .FAIR_LIM(4)) dut (
    .clk_p(clk_p), .rst_top(rst_top),
    .jt_req(jt_req), .jt_we(jt_we), .jt_inc(jt_inc), .jt_addr(jt_addr), .jt_wdata(jt_wdata),
    .jt_gnt(jt_gnt), .jt_rvalid(jt_rvalid), .jt_rdata(jt_rdata),
    .sys_req(sys_req), .sys_we(sys_we), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_gnt(sys_gnt), .sys_rvalid(sys_rvalid), .sys_rdata(sys_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One JTAG access: request at a negedge, check the ISSUE cycle, then the return cycle.
  task automatic jt_access(input logic we, input logic inc, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [31:0] rd, input string tag);
    jt_req = 1'b1; jt_we = we; jt_inc = inc; jt_addr = addr; jt_wdata = wdata;
    @(negedge clk_p);
    chk({tag, "_gnt"},    32'(jt_gnt), 32'd1);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_addr"},   mem_addr,    exp_addr);
    jt_req = 1'b0;
    mem_rdata = rd;
    @(negedge clk_p);
    chk({tag, "_rvalid"}, 32'(jt_rvalid), we ? 32'd0 : 32'd1);
    chk({tag, "_rdata"},  jt_rdata,       we ? 32'd0 : rd);
    chk({tag, "_en_off"}, 32'(mem_en),    32'd0);
    mem_rdata = '0;
  endtask

  logic [9:0] exp_sys_seq;

  initial begin
    rst_top = 1'b0;
    jt_req = 0; jt_we = 0; jt_inc = 0; jt_addr = '0; jt_wdata = '0;
    sys_req = 0; sys_we = 0; sys_addr = '0; sys_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk_p);
    chk("rst_jt_gnt",    32'(jt_gnt),     32'd0);
    chk("rst_sys_gnt",   32'(sys_gnt),    32'd0);
    chk("rst_mem_en",    32'(mem_en),     32'd0);
    chk("rst_mem_we",    32'(mem_we),     32'd0);
    chk("rst_mem_addr",  mem_addr,        32'd0);
    chk("rst_mem_wdata", mem_wdata,       32'd0);
    chk("rst_owner",     32'(owner),      32'd0);
    chk("rst_jt_rvalid", 32'(jt_rvalid),  32'd0);
    chk("rst_sys_rvalid",32'(sys_rvalid), 32'd0);
    rst_top = 1'b1;
    @(negedge clk_p);

    // Explicit-address read, then auto-increment reads from the loaded pointer.
    jt_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h100, 32'hCAFEF00D, "rd_expl");
    chk("rd_expl_other_rv", 32'(sys_rvalid), 32'd0);
    jt_access(1'b0, 1'b1, 32'h0, 32'h0, 32'h101, 32'h11111111, "inc1");
    jt_access(1'b0, 1'b1, 32'h0, 32'h0, 32'h102, 32'h22222222, "inc2");
    jt_access(1'b0, 1'b1, 32'h0, 32'h0, 32'h103, 32'h33333333, "inc3");

    // Pointer wrap from all-ones.
    jt_access(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hA5A5A5A5, "wrap_ld");
    jt_access(1'b0, 1'b1, 32'h0, 32'h0, 32'h00000000, 32'h5A5A5A5A, "wrap_inc");

    // JTAG write: no read return.
    jt_access(1'b1, 1'b0, 32'h44, 32'hBEEF, 32'h44, 32'h0, "jt_wr");
    chk("jt_wr_wdata_hold", mem_wdata, 32'hBEEF);

    // Both requesting continuously.
`ifdef JTAG_ARB_FAIR_EN
    exp_sys_seq = 10'b10000_10000;
`else
    exp_sys_seq = 10'b00000_00000;
`endif
    jt_req = 1; jt_we = 0; jt_inc = 0; jt_addr = 32'h300;
    sys_req = 1; sys_we = 0; sys_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_p);
      chk($sformatf("arb%0d_sys", i), 32'(sys_gnt), 32'(exp_sys_seq[i]));
      chk($sformatf("arb%0d_jt", i),  32'(jt_gnt),  32'(!exp_sys_seq[i]));
      @(negedge clk_p);
    end
    jt_req = 0; sys_req = 0;
    @(negedge clk_p);

    // System write while JTAG idle.
    sys_req = 1; sys_we = 1; sys_addr = 32'h20; sys_wdata = 32'h55;
    @(negedge clk_p);
    chk("sw_gnt",    32'(sys_gnt), 32'd1);
    chk("sw_jt_gnt", 32'(jt_gnt),  32'd0);
    chk("sw_we",     32'(mem_we),  32'd1);
    chk("sw_addr",   mem_addr,     32'h20);
    chk("sw_wdata",  mem_wdata,    32'h55);
    chk("sw_owner",  32'(owner),   32'd1);
    sys_req = 0;
    @(negedge clk_p);
    chk("sw_rvalid", 32'(sys_rvalid), 32'd0);
    chk("sw_rdata",  sys_rdata,       32'd0);

    // System read: data returns on system side only.
    sys_req = 1; sys_we = 0; sys_addr = 32'h40;
    @(negedge clk_p);
    chk("sr_gnt", 32'(sys_gnt), 32'd1);
    sys_req = 0; mem_rdata = 32'h12345678;
    @(negedge clk_p);
    chk("sr_rvalid",    32'(sys_rvalid), 32'd1);
    chk("sr_rdata",     sys_rdata,       32'h12345678);
    chk("sr_jt_rvalid", 32'(jt_rvalid),  32'd0);
    chk("sr_jt_rdata",  jt_rdata,        32'd0);
    mem_rdata = '0;

    // Reset during ISSUE of a JTAG read.
    jt_req = 1; jt_we = 0; jt_inc = 0; jt_addr = 32'h500;
    @(negedge clk_p);
    chk("mr_gnt", 32'(jt_gnt), 32'd1);
    rst_top = 1'b0; jt_req = 0; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("mr_rst_gnt",   32'(jt_gnt),   32'd0);
    chk("mr_rst_en",    32'(mem_en),   32'd0);
    chk("mr_rst_addr",  mem_addr,      32'd0);
    chk("mr_rst_owner", 32'(owner),    32'd0);
    chk("mr_rst_rdata", jt_rdata,      32'd0);
    @(negedge clk_p);
    rst_top = 1'b1;
    @(negedge clk_p);
    chk("mr_post_rvalid", 32'(jt_rvalid), 32'd0);
    chk("mr_post_gnt",    32'(jt_gnt),    32'd0);
    chk("mr_post_en",     32'(mem_en),    32'd0);
    mem_rdata = '0;
    jt_access(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, "mr_ptr0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
